// File: rtl/energy_accum_pkg.sv
// Shared widths, result entry layout and gain/saturation helper for energy_channel_accum.
// The entry carries a peak field only when PEAK_HOLD_EN is defined.
package energy_accum_pkg;

  localparam int DEF_CH_N       = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_AVG_LOG2   = 3;
  localparam int DEF_OUT_W      = 8;
  localparam int DEF_GAIN_W     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W    = ch_width(DEF_CH_N);
  localparam int SCALE_W = DEF_DATA_W + DEF_OUT_W + (1 << DEF_GAIN_W);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DEF_OUT_W-1:0]  avg;
`ifdef PEAK_HOLD_EN
    logic [DEF_DATA_W-1:0] peak;
`endif
  } result_t;

  // Wide enough that the largest shift of the largest average never wraps before the saturation test.
  function automatic logic [DEF_OUT_W-1:0] scale_sat(input logic [DEF_DATA_W-1:0] avg,
                                                     input logic [DEF_GAIN_W-1:0] sh);
    logic [SCALE_W-1:0] wide;
    wide = SCALE_W'(avg) << sh;
    if (wide[SCALE_W-1:DEF_OUT_W] != '0) return '1;
    return wide[DEF_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/energy_result_fifo.sv
// Result queue with a registered first-word-fall-through head; entries stay counted until popped.
// A freshly pushed entry reaches the head register one edge after it is written.
module energy_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d, remain;
  logic             doPush;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & (~full_o | pop_i);

  always_comb begin
    remain  = count_q - (PTR_W+1)'(pop_i);
    count_d = remain + (PTR_W+1)'(doPush);
    rdPtr_d = rdPtr_q + PTR_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  // The head is refreshed from storage as it stood before this edge's write, which gives the extra stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + PTR_W'(doPush);
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (remain != '0) begin
        valid_o <= 1'b1;
        data_o  <= mem_q[rdPtr_d];
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/energy_channel_accum.sv
// Multi-channel windowed sample averager with gain shift, saturation and a result FIFO.
// Optional macro PEAK_HOLD_EN adds a per-window raw-sample peak carried out as out_peak.
module energy_channel_accum
  import energy_accum_pkg::*;
#(
  parameter int CH_N       = DEF_CH_N,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int GAIN_W     = DEF_GAIN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      in_valid,
  input  logic [ch_width(CH_N)-1:0] in_ch,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [GAIN_W-1:0]         gain_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ch_width(CH_N)-1:0] out_ch,
  output logic [OUT_W-1:0]          out_avg,
  output logic [DATA_W-1:0]         out_peak,
  output logic                      ovf,
  output logic                      bad_ch,
  input  logic                      clr_flags
);

  localparam int CHW   = ch_width(CH_N);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q [CH_N];
  logic [CNT_W-1:0]  cnt_q [CH_N];
  logic              chOk, take, complete;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  result_t           res_d, res_q, head;
  logic              resValid_q;
  logic              fifoFull, fifoEmpty, fifoValid, pop;
  logic              ovf_q, badCh_q;

  generate
    if (CH_N == (1 << CHW)) begin : g_all_tags_valid
      assign chOk = 1'b1;
    end else begin : g_tag_range
      assign chOk = (in_ch < CHW'(CH_N));
    end
  endgenerate

  assign take     = ena & in_valid & chOk;
  assign complete = (cnt_q[in_ch] == CNT_LAST);
  assign sum      = acc_q[in_ch] + ACC_W'(in_data);
  assign avg      = sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_N; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (take) begin
      acc_q[in_ch] <= complete ? '0 : sum;
      cnt_q[in_ch] <= complete ? '0 : cnt_q[in_ch] + CNT_W'(1);
    end
  end

`ifdef PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_q [CH_N];
  logic [DATA_W-1:0] newPeak;

  assign newPeak = (in_data > peak_q[in_ch]) ? in_data : peak_q[in_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_N; c++) peak_q[c] <= '0;
    end else if (take) begin
      peak_q[in_ch] <= complete ? '0 : newPeak;
    end
  end
`endif

  always_comb begin
    res_d     = '0;
    res_d.ch  = in_ch;
    res_d.avg = scale_sat(avg, gain_shift);
`ifdef PEAK_HOLD_EN
    res_d.peak = newPeak;
`endif
  end

  // Gain is captured here, on the completing edge, so later gain changes never touch a finished window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resValid_q <= 1'b0;
      res_q      <= '0;
    end else begin
      resValid_q <= take & complete;
      if (take & complete) res_q <= res_d;
    end
  end

  assign pop = fifoValid & out_ready & ~fifoEmpty;

  energy_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(result_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (resValid_q),
    .data_i  (res_q),
    .pop_i   (pop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .valid_o (fifoValid),
    .data_o  (head)
  );

  assign out_valid = fifoValid;
  assign out_ch    = head.ch;
  assign out_avg   = head.avg;
`ifdef PEAK_HOLD_EN
  assign out_peak  = head.peak;
`else
  assign out_peak  = '0;
`endif

  // A set event in the same cycle as clr_flags keeps the flag asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      badCh_q <= 1'b0;
    end else begin
      ovf_q   <= (resValid_q & fifoFull & ~pop) | (ovf_q & ~clr_flags);
      badCh_q <= (ena & in_valid & ~chOk) | (badCh_q & ~clr_flags);
    end
  end

  assign ovf    = ovf_q;
  assign bad_ch = badCh_q;

endmodule

// File: tb/tb_energy_channel_accum.sv
// Self-checking bench for energy_channel_accum (default 4 channels, 8-sample windows, 4-entry FIFO).
// Expected results come from a plain-arithmetic model of windowed averaging; peak checks follow PEAK_HOLD_EN.
module tb_energy_channel_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_data;
  logic [1:0] gain_shift;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [7:0] out_avg;
  logic [7:0] out_peak;
  logic       ovf;
  logic       bad_ch;
  logic       clr_flags;

  int checks   = 0;
  int failures = 0;

`ifdef PEAK_HOLD_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  typedef struct {
    int ch;
    int avg;
    int peak;
  } exp_t;

  always #5 clk = ~clk;

  energy_channel_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .gain_shift (gain_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_avg    (out_avg),
    .out_peak   (out_peak),
    .ovf        (ovf),
    .bad_ch     (bad_ch),
    .clr_flags  (clr_flags)
  );

  // Average of an 8-sample window times 2**gain, clipped to the 8-bit range.
  function automatic int modelResult(input int total, input int gain);
    int r;
    r = (total / 8) * (1 << gain);
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic int peakExp(input int p);
    return PEAK_ON ? p : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendSample(input int ch, input int data);
    in_ch    = 2'(ch);
    in_data  = 8'(data);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic popHead(output int ch, output int avg, output int peak, output bit got);
    got  = 1'b0;
    ch   = 0;
    avg  = 0;
    peak = 0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    if (out_valid) begin
      ch        = int'(out_ch);
      avg       = int'(out_avg);
      peak      = int'(out_peak);
      got       = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ch !== 2'd0) begin failures++; $display("[TB] FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (out_avg !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_avg got=%0d exp=0", out_avg); end
    checks++; if (out_peak !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_peak got=%0d exp=0", out_peak); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (bad_ch !== 1'b0) begin failures++; $display("[TB] FAIL reset_bad_ch got=%0b exp=0", bad_ch); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int expAvg;
    gain_shift = 2'd1;
    expAvg     = modelResult(8 * 25, 1);
    for (int i = 0; i < 8; i++) sendSample(0, 25);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_edge0 got=%0b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_edge1 got=%0b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency_edge2 got=%0b exp=1", out_valid); end
    checks++; if (int'(out_ch) !== 0) begin failures++; $display("[TB] FAIL basic_ch got=%0d exp=0", out_ch); end
    checks++; if (int'(out_avg) !== expAvg) begin failures++; $display("[TB] FAIL basic_avg got=%0d exp=%0d", out_avg, expAvg); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty got=%0b exp=0", out_valid); end
    checks++; if (int'(out_avg) !== expAvg) begin failures++; $display("[TB] FAIL basic_hold got=%0d exp=%0d", out_avg, expAvg); end
  endtask

  task automatic test_interleave();
    int ch, avg, pk;
    bit got;
    gain_shift = 2'd1;
    for (int i = 0; i < 8; i++) begin
      sendSample(1, 10);
      sendSample(2, 45);
    end
    popHead(ch, avg, pk, got);
    checks++; if (!got || ch !== 1 || avg !== modelResult(80, 1)) begin failures++; $display("[TB] FAIL interleave_first got=%0b ch=%0d avg=%0d exp ch=1 avg=%0d", got, ch, avg, modelResult(80, 1)); end
    popHead(ch, avg, pk, got);
    checks++; if (!got || ch !== 2 || avg !== modelResult(360, 1)) begin failures++; $display("[TB] FAIL interleave_second got=%0b ch=%0d avg=%0d exp ch=2 avg=%0d", got, ch, avg, modelResult(360, 1)); end
  endtask

  task automatic test_saturate();
    int ch, avg, pk;
    bit got;
    gain_shift = 2'd1;
    for (int i = 0; i < 8; i++) sendSample(3, 255);
    popHead(ch, avg, pk, got);
    checks++; if (!got || ch !== 3 || avg !== modelResult(8 * 255, 1)) begin failures++; $display("[TB] FAIL saturate got=%0b ch=%0d avg=%0d exp=%0d", got, ch, avg, modelResult(8 * 255, 1)); end
    gain_shift = 2'd0;
    for (int i = 1; i <= 8; i++) sendSample(3, i);
    popHead(ch, avg, pk, got);
    checks++; if (!got || avg !== modelResult(36, 0)) begin failures++; $display("[TB] FAIL truncate got=%0b avg=%0d exp=%0d", got, avg, modelResult(36, 0)); end
  endtask

  task automatic test_overflow();
    exp_t q[$];
    exp_t e, rem[$];
    int   chans[5] = '{0, 1, 2, 3, 0};
    int   g, v, nv, ch, avg, pk;
    bit   got;
    g          = $urandom_range(0, 3);
    gain_shift = 2'(g);
    out_ready  = 1'b0;
    for (int w = 0; w < 5; w++) begin
      v = $urandom_range(0, 255);
      for (int i = 0; i < 8; i++) sendSample(chans[w], v);
      e.ch = chans[w]; e.avg = modelResult(8 * v, g); e.peak = peakExp(v);
      q.push_back(e);
    end
    tick(); tick(); tick();
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%0b exp=1", ovf); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%0b exp=0", ovf); end
    checks++; if (out_valid !== 1'b1 || int'(out_avg) !== q[0].avg) begin failures++; $display("[TB] FAIL full_head valid=%0b avg=%0d exp=%0d", out_valid, out_avg, q[0].avg); end
    // A completion whose push lands on the same edge as a pop from the full queue.
    nv = $urandom_range(0, 255);
    for (int i = 0; i < 8; i++) sendSample(1, nv);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL full_push_pop_ovf got=%0b exp=0", ovf); end
    rem = q[1:3];
    e.ch = 1; e.avg = modelResult(8 * nv, g); e.peak = peakExp(nv);
    rem.push_back(e);
    foreach (rem[i]) begin
      popHead(ch, avg, pk, got);
      checks++; if (!got || ch !== rem[i].ch || avg !== rem[i].avg || pk !== rem[i].peak) begin failures++; $display("[TB] FAIL drain_%0d got=%0b ch=%0d avg=%0d peak=%0d exp ch=%0d avg=%0d peak=%0d", i, got, ch, avg, pk, rem[i].ch, rem[i].avg, rem[i].peak); end
    end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_ena_freeze();
    int total, v, ch, avg, pk;
    bit got;
    gain_shift = 2'd1;
    total      = 0;
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 255);
      total += v;
      sendSample(2, v);
    end
    ena = 1'b0;
    for (int i = 0; i < 4; i++) sendSample(2, $urandom_range(0, 255));
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ena_frozen got=%0b exp=0", out_valid); end
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 255);
      total += v;
      sendSample(2, v);
    end
    popHead(ch, avg, pk, got);
    checks++; if (!got || ch !== 2 || avg !== modelResult(total, 1)) begin failures++; $display("[TB] FAIL ena_resume got=%0b ch=%0d avg=%0d exp=%0d", got, ch, avg, modelResult(total, 1)); end
    checks++; if (bad_ch !== 1'b0) begin failures++; $display("[TB] FAIL bad_ch_all_tags_valid got=%0b exp=0", bad_ch); end
  endtask

  task automatic test_peak_reset();
    int vals[8] = '{3, 9, 1, 7, 2, 2, 2, 2};
    int total, mx, ch, avg, pk;
    bit got;
    gain_shift = 2'd0;
    total = 0;
    mx    = 0;
    foreach (vals[i]) begin
      total += vals[i];
      if (vals[i] > mx) mx = vals[i];
      sendSample(0, vals[i]);
    end
    popHead(ch, avg, pk, got);
    checks++; if (!got || avg !== modelResult(total, 0) || pk !== peakExp(mx)) begin failures++; $display("[TB] FAIL peak_window got=%0b avg=%0d peak=%0d exp avg=%0d peak=%0d", got, avg, pk, modelResult(total, 0), peakExp(mx)); end
    for (int i = 0; i < 8; i++) sendSample(3, 200);
    for (int i = 0; i < 3; i++) sendSample(1, 50);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_queued got=%0b exp=1", out_valid); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_avg !== 8'd0 || out_peak !== 8'd0 || ovf !== 1'b0) begin failures++; $display("[TB] FAIL midrun_reset valid=%0b ch=%0d avg=%0d peak=%0d ovf=%0b exp all 0", out_valid, out_ch, out_avg, out_peak, ovf); end
    tick();
    rst_n = 1'b1;
    tick();
    gain_shift = 2'd1;
    for (int i = 0; i < 8; i++) sendSample(1, 60);
    popHead(ch, avg, pk, got);
    checks++; if (!got || ch !== 1 || avg !== modelResult(480, 1)) begin failures++; $display("[TB] FAIL post_reset_window got=%0b ch=%0d avg=%0d exp ch=1 avg=%0d", got, ch, avg, modelResult(480, 1)); end
  endtask

  task automatic test_random();
    int   sum[4], cnt[4], pk[4];
    exp_t q[$];
    exp_t e;
    int   d, c, g;
    doReset();
    for (int i = 0; i < 4; i++) begin sum[i] = 0; cnt[i] = 0; pk[i] = 0; end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 830; cyc++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL rand_unexpected got ch=%0d avg=%0d exp none", out_ch, out_avg);
        end else begin
          e = q.pop_front();
          checks++; if (int'(out_ch) !== e.ch || int'(out_avg) !== e.avg || int'(out_peak) !== e.peak) begin failures++; $display("[TB] FAIL rand_result got ch=%0d avg=%0d peak=%0d exp ch=%0d avg=%0d peak=%0d", out_ch, out_avg, out_peak, e.ch, e.avg, e.peak); end
        end
      end
      if (cyc < 800) begin
        ena        = ($urandom_range(0, 9) != 0);
        in_valid   = 1'($urandom_range(0, 1));
        c          = $urandom_range(0, 3);
        d          = $urandom_range(0, 255);
        g          = $urandom_range(0, 3);
        in_ch      = 2'(c);
        in_data    = 8'(d);
        gain_shift = 2'(g);
        if (ena && in_valid) begin
          sum[c] += d;
          cnt[c] += 1;
          if (d > pk[c]) pk[c] = d;
          if (cnt[c] == 8) begin
            e.ch = c; e.avg = modelResult(sum[c], g); e.peak = peakExp(pk[c]);
            q.push_back(e);
            sum[c] = 0; cnt[c] = 0; pk[c] = 0;
          end
        end
      end else begin
        in_valid = 1'b0;
        ena      = 1'b1;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (q.size() != 0) begin failures++; $display("[TB] FAIL rand_leftover got=%0d pending exp=0", q.size()); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL rand_ovf got=%0b exp=0", ovf); end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    in_valid   = 1'b0;
    in_ch      = 2'd0;
    in_data    = 8'd0;
    gain_shift = 2'd1;
    out_ready  = 1'b0;
    clr_flags  = 1'b0;
    test_reset();
    test_basic();
    test_interleave();
    test_saturate();
    test_overflow();
    test_ena_freeze();
    test_peak_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
